// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_ctrl
//  Purpose  : Steps the duty value of a PWM core toward a commanded target,
//             one STEP per PWM period. Mode 0 ramps to the target and stops
//             with a done pulse; mode 1 "breathes" between 0 and the target
//             until a new command preempts it.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous, active-low reset
//             cmd_valid  - command offered
//             cmd_ready  - command can be accepted (idle or breathing)
//             cmd_target - requested duty (clamped to PERIOD)
//             cmd_mode   - 0 = ramp and stop, 1 = breathe
//             cyc_done   - one-clock pulse from the PWM core per period end
//             duty       - registered on-time value for the PWM core
//             duty_load  - one-clock pulse in the cycle duty changes
//             busy       - controller is ramping or breathing
//             done       - one-clock pulse when a mode-0 ramp completes
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int PERIOD = 100,
  parameter int STEP   = 20,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_target,
  input  logic         cmd_mode,
  input  logic         cyc_done,
  output logic [W-1:0] duty,
  output logic         duty_load,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] c_period = W'(PERIOD);
  localparam logic [W-1:0] c_step_w = W'(STEP);
  localparam logic [W:0]   c_step_x = (W+1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_duty;
  logic [W-1:0] r_target;
  logic         r_mode;
  logic         r_duty_load;
  logic         r_done;

  logic         w_accept;
  logic [W-1:0] w_tgt_clamp;
  logic         w_eff_mode;
  logic [W:0]   w_sum;
  logic [W-1:0] w_up_next;
  logic [W-1:0] w_floor;
  logic [W:0]   w_floor_plus;
  logic [W-1:0] w_dn_next;

  // Commands are taken when idle or while breathing (r_mode is only ever 1
  // during a breathe, so it doubles as the "preemptable" flag).
  assign cmd_ready = (r_state == S_IDLE) | r_mode;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;

  assign w_tgt_clamp = (cmd_target > c_period) ? c_period : cmd_target;
  // A breathe toward 0 has nothing to breathe over: treat it as a mode-0 ramp.
  assign w_eff_mode  = cmd_mode & (w_tgt_clamp != '0);

  // Up step computed one bit wider so duty+STEP cannot wrap before the clamp.
  assign w_sum     = {1'b0, r_duty} + c_step_x;
  assign w_up_next = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[W-1:0];

  // Down step saturates at the floor; the compare guards the subtraction.
  assign w_floor      = r_mode ? '0 : r_target;
  assign w_floor_plus = {1'b0, w_floor} + c_step_x;
  assign w_dn_next    = ({1'b0, r_duty} >= w_floor_plus) ? (r_duty - c_step_w) : w_floor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_duty      <= '0;
      r_target    <= '0;
      r_mode      <= 1'b0;
      r_duty_load <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_duty_load <= 1'b0;
      r_done      <= 1'b0;
      if (w_accept) begin
        // An accept has priority: a coincident cyc_done does not step.
        r_target <= w_tgt_clamp;
        r_mode   <= w_eff_mode;
        if (w_eff_mode) begin
          r_state <= S_UP;
        end else if (w_tgt_clamp > r_duty) begin
          r_state <= S_UP;
        end else if (w_tgt_clamp < r_duty) begin
          r_state <= S_DOWN;
        end else begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
      end else if (cyc_done) begin
        case (r_state)
          S_UP: begin
            r_duty      <= w_up_next;
            r_duty_load <= (w_up_next != r_duty);
            if (w_up_next == r_target) begin
              if (r_mode) begin
                r_state <= S_DOWN;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          S_DOWN: begin
            r_duty      <= w_dn_next;
            r_duty_load <= (w_dn_next != r_duty);
            if (w_dn_next == w_floor) begin
              if (r_mode) begin
                r_state <= S_UP;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign duty      = r_duty;
  assign duty_load = r_duty_load;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_ramp_ctrl
//  Purpose  : Self-checking bench for pwm_ramp_ctrl. A behavioural model of
//             the ramp rules (integer duty, target, mode and direction) is
//             advanced at every clock edge and compared with the outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

  localparam int PERIOD = 100;
  localparam int STEP   = 20;
  localparam int W      = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_target = '0;
  logic         cmd_mode = 1'b0;
  logic         cyc_done = 1'b0;
  logic [W-1:0] duty;
  logic         duty_load;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_duty, m_target;
  bit m_mode, m_busy, m_up, m_load, m_done;

  pwm_ramp_ctrl #(.PERIOD(PERIOD), .STEP(STEP), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_mode   (cmd_mode),
    .cyc_done   (cyc_done),
    .duty       (duty),
    .duty_load  (duty_load),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_duty = 0; m_target = 0; m_mode = 0; m_busy = 0; m_up = 0;
    m_load = 0; m_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit acc;
    int t, nd, fl;
    m_load = 0;
    m_done = 0;
    acc = cmd_valid && (!m_busy || m_mode);
    if (acc) begin
      t = (int'(cmd_target) > PERIOD) ? PERIOD : int'(cmd_target);
      m_target = t;
      m_mode = cmd_mode && (t != 0);
      if (m_mode) begin
        m_busy = 1; m_up = 1;
      end else if (t > m_duty) begin
        m_busy = 1; m_up = 1;
      end else if (t < m_duty) begin
        m_busy = 1; m_up = 0;
      end else begin
        m_busy = 0; m_done = 1;
      end
    end else if (cyc_done && m_busy) begin
      if (m_up) begin
        nd = m_duty + STEP;
        if (nd > m_target) nd = m_target;
        m_load = (nd != m_duty);
        m_duty = nd;
        if (nd == m_target) begin
          if (m_mode) m_up = 0;
          else begin m_busy = 0; m_done = 1; end
        end
      end else begin
        fl = m_mode ? 0 : m_target;
        nd = m_duty - STEP;
        if (nd < fl) nd = fl;
        m_load = (nd != m_duty);
        m_duty = nd;
        if (nd == fl) begin
          if (m_mode) m_up = 1;
          else begin m_busy = 0; m_done = 1; end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("duty", 32'(duty), 32'(m_duty));
    chk("duty_load", 32'(duty_load), 32'(m_load));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy || m_mode));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int t, input bit mode, input bit cyc);
    cmd_valid  = 1'b1;
    cmd_target = W'(t);
    cmd_mode   = mode;
    cyc_done   = cyc;
    tick();
    cmd_valid  = 1'b0;
    cyc_done   = 1'b0;
  endtask

  task automatic pulse();
    cyc_done = 1'b1;
    tick();
    cyc_done = 1'b0;
  endtask

  int up_exp[6]      = '{20, 40, 60, 80, 100, 100};
  int dn_exp[3]      = '{80, 60, 50};
  int breathe_exp[8] = '{20, 40, 60, 40, 20, 0, 20, 40};
  int stop_exp[2]    = '{20, 0};

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Mode-0 ramp up to 100
    send(100, 0, 0);
    for (int i = 0; i < 6; i++) begin
      idle(2);
      pulse();
      chk("up_duty", 32'(duty), 32'(up_exp[i]));
      chk("up_load", 32'(duty_load), 32'(i < 5));
      chk("up_done", 32'(done), 32'(i == 4));
    end
    idle(2);

    // Mode-0 ramp down with saturation at 50
    send(50, 0, 0);
    chk("ramp_ready", 32'(cmd_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      idle(2);
      pulse();
      chk("dn_duty", 32'(duty), 32'(dn_exp[i]));
      chk("dn_done", 32'(done), 32'(i == 2));
    end
    idle(2);

    // Clamped target, then equal target
    send(150, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      pulse();
    end
    chk("clamp_duty", 32'(duty), 32'(100));
    idle(2);
    send(100, 0, 0);
    chk("eq_done", 32'(done), 32'(1));
    chk("eq_load", 32'(duty_load), 32'(0));
    idle(2);

    // Ramp to 0 to start the breathe from a known point
    send(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      idle(2);
      pulse();
    end
    idle(2);

    // Breathe to 60, then preempt at duty 40 with a mode-0 target of 0
    send(60, 1, 0);
    for (int i = 0; i < 8; i++) begin
      idle(2);
      pulse();
      chk("breathe_duty", 32'(duty), 32'(breathe_exp[i]));
      chk("breathe_done", 32'(done), 32'(0));
    end
    idle(1);
    chk("breathe_ready", 32'(cmd_ready), 32'(1));
    send(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      idle(2);
      pulse();
      chk("stop_duty", 32'(duty), 32'(stop_exp[i]));
      chk("stop_done", 32'(done), 32'(i == 1));
    end
    idle(2);

    // Accept coincident with cyc_done does not step
    send(60, 0, 1);
    chk("coinc_duty", 32'(duty), 32'(0));
    chk("coinc_load", 32'(duty_load), 32'(0));
    idle(2);
    pulse();
    chk("coinc_first", 32'(duty), 32'(20));
    idle(2);

    // Asynchronous reset mid-ramp, away from any clock edge
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_duty", 32'(duty), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    check_all();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      pulse();
    end
    chk("post_rst_duty", 32'(duty), 32'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cmd_valid  = ($urandom_range(0, 5) == 0);
      cmd_target = W'($urandom_range(0, 255));
      cmd_mode   = $urandom_range(0, 1) == 1;
      cyc_done   = ($urandom_range(0, 2) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    cyc_done  = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 100: PWM period in clocks and the maximum duty value.
REQ-002 SHALL have parameter STEP, default 20: duty increment or decrement applied per PWM cycle.
REQ-003 SHALL have parameter W, default 8: width of the duty and target ports; PERIOD SHALL be representable in W bits.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-007 SHALL have port cmd_ready, output, 1: the controller can accept a command.
REQ-008 SHALL have port cmd_target, input, W: target duty.
REQ-009 SHALL have port cmd_mode, input, 1: 0 = ramp to target then stop; 1 = breathe between 0 and target.
REQ-010 SHALL have port cyc_done, input, 1: one-clock pulse from the PWM core at each period end.
REQ-011 SHALL have port duty, output, W: on-time value driven to the PWM core.
REQ-012 SHALL have port duty_load, output, 1: one-clock pulse in every cycle that duty changes.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1: one-clock pulse when a mode-0 ramp completes.

Function
REQ-015 SHALL accept a command only in a cycle where cmd_valid=1 and cmd_ready=1.
REQ-016 SHALL drive cmd_ready=1 in IDLE and while breathing (mode 1); otherwise 0.
REQ-017 SHALL latch the target at acceptance as min(cmd_target, PERIOD), and latch the mode.
REQ-018 SHALL implement states IDLE, UP and DOWN.
REQ-019 On a mode-0 accept, SHALL go to UP if target > duty, to DOWN if target < duty, and stay in IDLE with a done pulse on the next cycle (no duty_load) if target = duty.
REQ-020 On a mode-1 accept with target > 0, SHALL go to UP; a mode-1 target of 0 SHALL be handled as a mode-0 target of 0.
REQ-021 SHALL change duty only on cyc_done; a cyc_done in the same cycle as a command accept SHALL be ignored for stepping.
REQ-022 In UP on cyc_done, SHALL set duty to min(duty+STEP, target), computed without overflow at W bits.
REQ-023 In DOWN on cyc_done, SHALL set duty to max(duty-STEP, floor), where floor = target in mode 0 and floor = 0 in mode 1, with no underflow.
REQ-024 duty and duty_load SHALL be registered; duty_load SHALL be high in the cycle after the triggering cyc_done, which is the same cycle the new duty appears.
REQ-025 In mode 0, when duty reaches target, SHALL go to IDLE and pulse done in the same cycle as that duty_load.
REQ-026 In mode 1, on reaching target in UP, SHALL go to DOWN; on reaching 0 in DOWN, SHALL go to UP; done SHALL never pulse.
REQ-027 A command accepted while breathing SHALL preempt immediately and take effect from the current duty per REQ-019 and REQ-020.
REQ-028 SHALL hold duty at its last value in IDLE.

Reset
REQ-029 While rst=0, SHALL asynchronously force state=IDLE, duty=0, duty_load=0, done=0, busy=0, cmd_ready=1, and latched target and mode to 0.
REQ-030 Reset asserted mid-ramp SHALL abandon the ramp; after release SHALL stay idle until a new command.

Verification
REQ-031 Reset: assert rst=0 mid-cycle -> duty=0, busy=0, cmd_ready=1 with no clock edge.
REQ-032 Mode-0 up: target=100, 6 cyc_done pulses -> duty 20, 40, 60, 80, 100; done coincides with the 5th duty_load; 6th pulse gives no load.
REQ-033 Mode-0 down with saturation: from duty=100, target=50 -> 80, 60, 50; then done; cmd_ready=0 during the ramp.
REQ-034 Clamp and equal target: target=150 -> final duty 100; then target=100 -> done next cycle with no duty_load.
REQ-035 Breathe: mode 1, target=60 -> 20, 40, 60, 40, 20, 0, 20 ...; a mode-0 command with target=0 accepted at duty=40 -> 20, 0, done.
REQ-036 Accept coincident with cyc_done: that pulse causes no step; the first step occurs on the next cyc_done.
